// File: rtl/laser_pkg.sv
// Shared constants, widths and state encoding for the two-circle laser search controller.
package laser_pkg;

    localparam int GRID         = 16;
    localparam int GROUPS       = 4;
    localparam int GROUP_SIZE   = 10;
    localparam int TOTAL_POINTS = GROUPS * GROUP_SIZE;

    localparam int CNT_W   = 4;  // per-group count, 0..10 in contract
    localparam int TOT_W   = 6;  // per-candidate total, 0..40 (holds 4 x 15)
    localparam int COORD_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        SWEEP,
        COMMIT,
        CHECK,
        DONE
    } state_t;

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [TOT_W-1:0]   total_t;
    typedef logic [TOT_W:0]     bound_t;
    typedef logic [COORD_W-1:0] coord_t;

    // Most points the groups after g can still add to a candidate's total.
    function automatic bound_t remaining_max(input logic [1:0] g);
        return bound_t'(GROUP_SIZE * (GROUPS - 1 - int'(g)));
    endfunction

endpackage

// File: rtl/laser_best_tracker.sv
// Per-candidate accumulator and strict-greater best-centre register.
// Build option LASER_PRUNE_EN ends a candidate early once it can no longer beat the best.
module laser_best_tracker
    import laser_pkg::*;
(
    input  logic   CLK,
    input  logic   RST,
    input  logic   clear,
    input  logic   enable,
    input  logic [1:0] grp,
    input  cnt_t   grp_cnt,
    input  coord_t cand_x,
    input  coord_t cand_y,
    output logic   cand_end,
    output total_t best_total,
    output coord_t best_x,
    output coord_t best_y,
    output coord_t win_x,
    output coord_t win_y
);

    total_t acc;
    total_t sum;
    logic   last_grp;
    logic   better;

    assign sum      = acc + TOT_W'(grp_cnt);
    assign last_grp = (grp == 2'(GROUPS - 1));
    // Strict compare: a later candidate with an equal total never displaces the earlier one.
    assign better   = last_grp && (sum > best_total);

`ifdef LASER_PRUNE_EN
    bound_t bound;
    assign bound    = bound_t'(sum) + remaining_max(grp);
    assign cand_end = last_grp || (bound <= bound_t'(best_total));
`else
    assign cand_end = last_grp;
`endif

    // Winner including the candidate finishing this cycle, for the SWEEP->COMMIT hand-off.
    assign win_x = (enable && better) ? cand_x : best_x;
    assign win_y = (enable && better) ? cand_y : best_y;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc        <= '0;
            best_total <= '0;
            best_x     <= '0;
            best_y     <= '0;
        end else if (clear) begin
            acc        <= '0;
            best_total <= '0;
            best_x     <= '0;
            best_y     <= '0;
        end else if (enable) begin
            acc <= cand_end ? '0 : sum;
            if (better) begin
                best_total <= sum;
                best_x     <= cand_x;
                best_y     <= cand_y;
            end
        end
    end

endmodule

// File: rtl/laser_search_ctrl.sv
// Two-circle laser search: raster-sweeps centres, commits each circle's best mask, alternates until stable.
// Build option LASER_PRUNE_EN (see laser_best_tracker) shortens sweeps without changing results.
module laser_search_ctrl #(
    parameter int MAX_ITER = 8,
    parameter int GRID     = 16,
    parameter int GROUPS   = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [3:0] grp_cnt,
    output logic [3:0] cx,
    output logic [3:0] cy,
    output logic [1:0] grp,
    output logic       circ_sel,
    output logic       mask_we,
    output logic [3:0] c1x,
    output logic [3:0] c1y,
    output logic [3:0] c2x,
    output logic [3:0] c2y,
    output logic       done
);
    import laser_pkg::*;

    localparam int         ITER_W     = $clog2(MAX_ITER + 1);
    localparam logic [3:0] LAST_COORD = 4'(GRID - 1);
    localparam logic [1:0] LAST_GRP   = 2'(GROUPS - 1);

    state_t state, state_nx;
    logic [3:0] cx_nx, cy_nx;
    logic [1:0] grp_nx;
    logic       sel_nx;
    logic [3:0] c1x_nx, c1y_nx, c2x_nx, c2y_nx;
    logic [ITER_W-1:0] iter, iter_nx;
    logic       same, same_nx;

    logic   trk_clear, trk_en, cand_end;
    total_t best_total;
    coord_t best_x, best_y, win_x, win_y;
    logic   unused_best_total;

    laser_best_tracker u_tracker (
        .CLK        (CLK),
        .RST        (RST),
        .clear      (trk_clear),
        .enable     (trk_en),
        .grp        (grp),
        .grp_cnt    (grp_cnt),
        .cand_x     (cx),
        .cand_y     (cy),
        .cand_end   (cand_end),
        .best_total (best_total),
        .best_x     (best_x),
        .best_y     (best_y),
        .win_x      (win_x),
        .win_y      (win_y)
    );

    assign unused_best_total = ^best_total;

    assign mask_we = (state == COMMIT);
    assign done    = (state == DONE);

    // NOTE: every signal of this block gets a default first; a missed branch would otherwise infer a latch.
    always_comb begin
        state_nx  = state;
        cx_nx     = cx;
        cy_nx     = cy;
        grp_nx    = grp;
        sel_nx    = circ_sel;
        c1x_nx    = c1x;
        c1y_nx    = c1y;
        c2x_nx    = c2x;
        c2y_nx    = c2y;
        iter_nx   = iter;
        same_nx   = same;
        trk_clear = 1'b0;
        trk_en    = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx  = SWEEP;
                    cx_nx     = '0;
                    cy_nx     = '0;
                    grp_nx    = '0;
                    sel_nx    = 1'b0;
                    c1x_nx    = '0;
                    c1y_nx    = '0;
                    c2x_nx    = '0;
                    c2y_nx    = '0;
                    iter_nx   = '0;
                    same_nx   = 1'b0;
                    trk_clear = 1'b1;
                end
            end

            SWEEP: begin
                trk_en = 1'b1;
                if (cand_end) begin
                    grp_nx = '0;
                    cx_nx  = cx + 4'd1;
                    if (cx == LAST_COORD) begin
                        cy_nx = cy + 4'd1;
                        if (cy == LAST_COORD) begin
                            state_nx = COMMIT;
                            cx_nx    = win_x;
                            cy_nx    = win_y;
                        end
                    end
                end else begin
                    grp_nx = grp + 2'd1;
                end
            end

            COMMIT: begin
                grp_nx = grp + 2'd1;
                if (grp == 2'd0) begin
                    // Compare against the centre this circle held before the sweep, then replace it.
                    if (circ_sel) begin
                        same_nx = (best_x == c2x) && (best_y == c2y);
                        c2x_nx  = best_x;
                        c2y_nx  = best_y;
                    end else begin
                        same_nx = (best_x == c1x) && (best_y == c1y);
                        c1x_nx  = best_x;
                        c1y_nx  = best_y;
                    end
                end
                if (grp == LAST_GRP) begin
                    state_nx = CHECK;
                end
            end

            CHECK: begin
                iter_nx = iter + ITER_W'(1);
                if ((same && (iter_nx >= ITER_W'(2))) || (iter_nx == ITER_W'(MAX_ITER))) begin
                    state_nx = DONE;
                end else begin
                    state_nx  = SWEEP;
                    sel_nx    = ~circ_sel;
                    cx_nx     = '0;
                    cy_nx     = '0;
                    grp_nx    = '0;
                    trk_clear = 1'b1;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cx       <= '0;
            cy       <= '0;
            grp      <= '0;
            circ_sel <= 1'b0;
            c1x      <= '0;
            c1y      <= '0;
            c2x      <= '0;
            c2y      <= '0;
            iter     <= '0;
            same     <= 1'b0;
        end else begin
            state    <= state_nx;
            cx       <= cx_nx;
            cy       <= cy_nx;
            grp      <= grp_nx;
            circ_sel <= sel_nx;
            c1x      <= c1x_nx;
            c1y      <= c1y_nx;
            c2x      <= c2x_nx;
            c2y      <= c2y_nx;
            iter     <= iter_nx;
            same     <= same_nx;
        end
    end

endmodule
